// File: rtl/uart_result_sender.sv
// Sends one 43-byte classification result packet (header, digit, 10 LE scores, XOR checksum)
// over an 8N1 UART line using its own bit-level transmitter.
module uart_result_sender #(
    parameter int unsigned CLKS_PER_BIT = 5209,
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
    input  logic         i_Clock,
    input  logic         i_Rst_L,
    input  logic         i_Start,
    input  logic [3:0]   i_Digit,
    input  logic [319:0] i_Scores,
    output logic         o_TX_Serial,
    output logic         o_Busy,
    output logic         o_Done
);
    localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [5:0]    LAST_BYTE = 6'd42;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clk_q, clk_d;
    logic [2:0]    bit_q, bit_d;
    logic [5:0]    byte_q, byte_d;
    logic [3:0]    digit_q, digit_d;
    logic [319:0]  scores_q, scores_d;
    logic [7:0]    chk_q, chk_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic [7:0]    in_chk;
    logic [343:0]  pkt;
    logic [7:0]    cur_byte;
    logic          bit_end;

    // Checksum covers the digit byte and all 40 score bytes, taken from the live inputs at accept.
    always_comb begin
        in_chk = {4'h0, i_Digit};
        for (int i = 0; i < 40; i++) begin
            in_chk = in_chk ^ i_Scores[8*i +: 8];
        end
    end

    assign pkt      = {chk_q, scores_q, 4'h0, digit_q, HEADER_BYTE};
    assign cur_byte = pkt[{byte_q, 3'b000} +: 8];
    assign bit_end  = (clk_q == CLK_LAST);

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= IDLE;
            clk_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            digit_q  <= '0;
            scores_q <= '0;
            chk_q    <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            clk_q    <= clk_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            digit_q  <= digit_d;
            scores_q <= scores_d;
            chk_q    <= chk_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    // tx_d carries the level of the bit that begins next cycle, so the line changes only at bit boundaries.
    always_comb begin
        state_d  = state_q;
        clk_d    = clk_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        digit_d  = digit_q;
        scores_d = scores_q;
        chk_d    = chk_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                clk_d  = '0;
                bit_d  = '0;
                byte_d = '0;
                if (i_Start) begin
                    state_d  = START;
                    tx_d     = 1'b0;
                    digit_d  = i_Digit;
                    scores_d = i_Scores;
                    chk_d    = in_chk;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    clk_d = clk_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    clk_d = clk_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        byte_d  = byte_q + 6'd1;
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end else begin
                    clk_d = clk_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                clk_d   = '0;
                bit_d   = '0;
                byte_d  = '0;
            end
        endcase
    end

    assign o_TX_Serial = tx_q;
    assign o_Busy      = (state_q != IDLE);
    assign o_Done      = done_q;
endmodule

// File: tb/tb_uart_result_sender.sv
// Bench for uart_result_sender: a sampling UART receiver decodes every packet and compares
// it against a packet model built directly from the digit and score values.
module tb_uart_result_sender;
    localparam int CPB = 4;
    localparam int NB  = 43;

    logic         clk    = 1'b0;
    logic         rst_l  = 1'b1;
    logic         start  = 1'b0;
    logic [3:0]   digit  = '0;
    logic [319:0] scores = '0;
    logic         tx, busy, done;

    uart_result_sender #(.CLKS_PER_BIT(CPB), .HEADER_BYTE(8'hA5)) dut (
        .i_Clock    (clk),
        .i_Rst_L    (rst_l),
        .i_Start    (start),
        .i_Digit    (digit),
        .i_Scores   (scores),
        .o_TX_Serial(tx),
        .o_Busy     (busy),
        .o_Done     (done)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_b[NB];

    typedef struct {
        logic [3:0]   digit;
        logic [319:0] scores;
        logic [7:0]   exp_b1;
        int           idx;
        logic [7:0]   exp_at;
        logic [7:0]   exp_chk;
    } vec_t;
    vec_t vecs[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet as a list of byte values; scores read as plain integers and split into bytes.
    function automatic void model_packet(input logic [3:0] d, input logic [319:0] s);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [31:0] sc;
        exp_q.push_back(8'hA5);
        x = {4'h0, d};
        exp_q.push_back(x);
        for (int k = 0; k < 10; k++) begin
            sc = s[32*k +: 32];
            for (int j = 0; j < 4; j++) begin
                b = 8'((sc >> (8*j)) & 32'hFF);
                exp_q.push_back(b);
                x = x ^ b;
            end
        end
        exp_q.push_back(x);
    endfunction

    task automatic send(input logic [3:0] d, input logic [319:0] s, input bit keep_start);
        @(negedge clk);
        check("idle busy before start", 64'(busy), 64'd0);
        check("done low before start", 64'(done), 64'd0);
        digit = d;
        scores = s;
        start = 1'b1;
        model_packet(d, s);
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
    endtask

    // action 1: pulse start and scramble inputs mid-packet; action 2: assert reset mid-packet.
    task automatic rx_packet(input string tag, input int action);
        logic [7:0] shreg;
        logic       s, s0;
        logic [7:0] e;
        int         notbusy, done_cnt, frame_err;
        notbusy = 0; done_cnt = 0; frame_err = 0; shreg = '0; s0 = 1'b0; s = 1'b0;
        for (int by = 0; by < NB; by++) begin
            for (int bi = 0; bi < 10; bi++) begin
                for (int c = 0; c < CPB; c++) begin
                    @(negedge clk);
                    if (action == 2 && by == 20 && bi == 0 && c == 0) begin
                        rst_l = 1'b0;
                        #1;
                        check({tag, " reset tx"}, 64'(tx), 64'd1);
                        check({tag, " reset busy"}, 64'(busy), 64'd0);
                        check({tag, " reset done"}, 64'(done), 64'd0);
                        exp_q.delete();
                        return;
                    end
                    s = tx;
                    if (busy !== 1'b1) notbusy++;
                    if (done !== 1'b0) done_cnt++;
                    if (c == 0) s0 = s;
                    else if (s !== s0) frame_err++;
                    if (action == 1 && by == 20 && bi == 0) begin
                        if (c == 0) begin
                            start = 1'b1;
                            digit = ~digit;
                            scores = ~scores;
                        end else if (c == 1) begin
                            start = 1'b0;
                        end
                    end
                end
                if (bi == 0) begin
                    if (s0 !== 1'b0) frame_err++;
                end else if (bi == 9) begin
                    if (s0 !== 1'b1) frame_err++;
                end else begin
                    shreg[bi-1] = s0;
                end
            end
            got_b[by] = shreg;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s byte%0d: got %0h expected none", tag, by, shreg);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s byte%0d", tag, by), 64'(shreg), 64'(e));
            end
        end
        check({tag, " framing errors"}, 64'(frame_err), 64'd0);
        check({tag, " busy gaps"}, 64'(notbusy), 64'd0);
        check({tag, " early done"}, 64'(done_cnt), 64'd0);
    endtask

    task automatic check_end(input string tag);
        @(negedge clk);
        check({tag, " done pulse"}, 64'(done), 64'd1);
        check({tag, " busy after"}, 64'(busy), 64'd0);
        check({tag, " line idle"}, 64'(tx), 64'd1);
    endtask

    initial begin
        logic [319:0] s;
        int           bad;

        // clock/reset
        #2 rst_l = 1'b0;
        #1;
        check("reset tx", 64'(tx), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;

        // directed table
        s = '0; s[3*32 +: 32] = 32'h0000_0100;
        vecs[0] = '{digit: 4'd3, scores: s, exp_b1: 8'h03, idx: 15, exp_at: 8'h01, exp_chk: 8'h02};
        s = '0; s[0 +: 32] = 32'hFFFF_FFFF;
        vecs[1] = '{digit: 4'd0, scores: s, exp_b1: 8'h00, idx: 5, exp_at: 8'hFF, exp_chk: 8'h00};
        s = '0;
        for (int k = 0; k < 10; k++) s[32*k +: 32] = 32'h1122_3344 + 32'(k);
        vecs[2] = '{digit: 4'd9, scores: s, exp_b1: 8'h09, idx: 38, exp_at: 8'h4D, exp_chk: 8'h08};

        for (int v = 0; v < 3; v++) begin
            send(vecs[v].digit, vecs[v].scores, 1'b0);
            rx_packet($sformatf("vec%0d", v), 0);
            check_end($sformatf("vec%0d", v));
            check($sformatf("vec%0d header", v), 64'(got_b[0]), 64'h A5);
            check($sformatf("vec%0d digit byte", v), 64'(got_b[1]), 64'(vecs[v].exp_b1));
            check($sformatf("vec%0d byte%0d", v, vecs[v].idx), 64'(got_b[vecs[v].idx]), 64'(vecs[v].exp_at));
            check($sformatf("vec%0d checksum", v), 64'(got_b[42]), 64'(vecs[v].exp_chk));
        end

        // randomized packets against the model
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
            send(4'($urandom_range(0, 15)), s, 1'b0);
            rx_packet($sformatf("rand%0d", r), 0);
            check_end($sformatf("rand%0d", r));
        end

        // start pulse and input change mid-packet
        for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
        send(4'd7, s, 1'b0);
        rx_packet("midchg", 1);
        check_end("midchg");
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        check("midchg no second packet", 64'(bad), 64'd0);

        // start held through done: second packet with no gap
        for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
        send(4'd5, s, 1'b1);
        rx_packet("b2b first", 0);
        check_end("b2b first");
        model_packet(4'd5, s);
        @(posedge clk);
        #1 start = 1'b0;
        rx_packet("b2b second", 0);
        check_end("b2b second");

        // reset during byte 20, then a clean packet
        for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
        send(4'd2, s, 1'b0);
        rx_packet("rstmid", 2);
        repeat (3) @(negedge clk);
        check("rstmid held tx", 64'(tx), 64'd1);
        rst_l = 1'b1;
        send(4'd8, s, 1'b0);
        rx_packet("after reset", 0);
        check_end("after reset");

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_result_sender.md
Name: uart_result_sender

Overview:
- Transmit-side counterpart to the 784-pixel UART image collector.
- Sends one classification result packet from the inference core back to the host over the same 8N1 UART link.
- On a start request it snapshots the 10 class scores (32-bit signed each) and the predicted digit.
- It then serializes a fixed 43-byte framed packet with an XOR checksum, using a built-in bit-level transmitter; no separate uart_tx instance.

Parameters:
CLKS_PER_BIT, 5209, clock cycles per UART bit (must be >= 2); must match the receive side.
HEADER_BYTE, 8'hA5, first byte of every packet.

Ports:
i_Clock  input  1  system clock
i_Rst_L  input  1  asynchronous, active-low reset
i_Start  input  1  request to send; sampled only while idle
i_Digit  input  4  predicted class (0-9); the value is sent unchecked
i_Scores  input  320  flattened scores; score k = i_Scores[32k+31:32k], signed, k=0..9
o_TX_Serial  output  1  UART line; idle high
o_Busy  output  1  high while a packet is in flight
o_Done  output  1  one-cycle pulse at packet completion

Behaviour:
- Reset (async, active-low): o_TX_Serial=1, o_Busy=0, o_Done=0. FSM goes to IDLE; byte/bit/clock counters and snapshot registers clear. Reset mid-packet aborts immediately; the line returns high with no further bits.
- Packet byte order, indices 0..42:
  - byte 0 = HEADER_BYTE.
  - byte 1 = {4'h0, i_Digit}.
  - bytes 2+4k+j = score k byte j, k=0..9, j=0..3, little-endian (j=0 is bits [7:0]).
  - byte 42 = XOR of bytes 1..41 (header excluded).
- Snapshot: i_Digit and i_Scores are captured in the cycle i_Start is accepted. Input changes afterwards do not affect the packet in flight.
- Accept rule: i_Start high at a rising edge while the FSM is in IDLE (o_Busy=0) starts a packet. i_Start while busy is ignored (not queued).
- States and transitions:
  - IDLE: line high; waits for i_Start, then START.
  - START: line 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: line 1 for CLKS_PER_BIT cycles. If byte index < 42, advance the index and go to START; otherwise go to IDLE and pulse o_Done.
- Timing:
  - i_Start accepted at edge t: from cycle t+1, o_Busy=1 and o_TX_Serial=0.
  - Bytes are back-to-back with no idle gap; each byte takes 10*CLKS_PER_BIT cycles.
  - o_Busy stays high for exactly 430*CLKS_PER_BIT cycles.
  - o_Done=1 for exactly one cycle: the first cycle after o_Busy falls, with o_TX_Serial=1.
  - A new i_Start is accepted in the same cycle o_Done is high. Its start bit then follows immediately after that cycle.
- Bit timing: one counter counts 0..CLKS_PER_BIT-1 per bit. A bit ends when the counter reaches CLKS_PER_BIT-1. Line transitions occur only at bit boundaries; no glitches (o_TX_Serial is registered).
- Checksum: may be computed at snapshot or incrementally. Byte 42 must equal the defined XOR regardless.
- Negative scores are sent as their two's-complement bytes; there is no saturation.
- Default state recovery: any unused FSM encoding returns to IDLE with the line high.

Test Plan:
- Reset during byte 20 of a packet (CLKS_PER_BIT=4) -> o_TX_Serial=1, o_Busy=0 immediately. Then after release, i_Start sends a full correct packet.
- CLKS_PER_BIT=4, digit=3, score3=32'h00000100, other scores 0 -> decoded bytes:
  - byte 0 = A5, byte 1 = 03.
  - byte 15 = 01; all other score bytes 00.
  - byte 42 = 02.
  - o_Busy high for 1720 cycles, o_Done pulses once.
- digit=0, score0=-1 (32'hFFFFFFFF), rest 0 -> bytes 2..5 = FF, checksum byte 42 = 00.
- Scores k = 32'h11223344+k, digit=9 -> each score is received little-endian (44+k,33,22,11 for k=0..9, no carry). Byte 42 matches the bench-computed XOR.
- i_Start pulsed again mid-packet, and i_Scores changed mid-packet -> packet unaffected and no second packet. i_Start held high through o_Done -> second packet starts the next cycle with no gap.
- Bit-timing check -> every bit held exactly CLKS_PER_BIT cycles; start bit low, stop bit high. A checker UART receiver decodes all 43 bytes.
